// File: rtl/inmux_slice.sv
// Two-entry elastic register slice behind the input-mux controller; all handshakes registered.
// Optional transfer counter and xfer_cnt port enabled by defining INMUX_SLICE_CNT_EN.
module inmux_slice #(
  parameter int WIDTH = 32
`ifdef INMUX_SLICE_CNT_EN
  , parameter int CNTW = 16
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             t_req,
  output logic             t_ack,
  input  logic [WIDTH-1:0] t_dat,
  output logic             i_req,
  input  logic             i_ack,
  output logic [WIDTH-1:0] i_dat,
  input  logic             flush
`ifdef INMUX_SLICE_CNT_EN
  , output logic [CNTW-1:0] xfer_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             t_ack_q;
  logic             i_req_q;
  logic             push;
  logic             pop;

  assign push  = t_req & t_ack_q;
  assign pop   = i_req_q & i_ack;
  assign t_ack = t_ack_q;
  assign i_req = i_req_q;
  assign i_dat = m_q;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          m_d     = t_dat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          m_d = t_dat;
        end else if (push) begin
          s_d     = t_dat;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything: a same-cycle push is dropped, storage left untouched.
    if (flush) begin
      state_d = EMPTY;
      m_d     = m_q;
      s_d     = s_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
      t_ack_q <= 1'b0;
      i_req_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      t_ack_q <= (state_d != FULL);
      i_req_q <= (state_d != EMPTY);
    end
  end

`ifdef INMUX_SLICE_CNT_EN
  logic [CNTW-1:0] cnt_q;

  // Pops during a flush cycle are genuine transfers, so flush never touches the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule
